// File: rtl/turn_pkg.sv
// Shared definitions for the turn-control FSMs: state encoding, index codes, timing.
package turn_pkg;
    localparam int ONE_SECOND = 65000000;

    localparam logic [1:0] IDX_IDLE  = 2'd0;
    localparam logic [1:0] IDX_HOLD  = 2'd1;
    localparam logic [1:0] IDX_THROW = 2'd2;

    typedef enum logic [2:0] {
        RS_IDLE  = 3'd0,
        RS_HOLD  = 3'd1,
        RS_THROW = 3'd2,
        RS_DONE  = 3'd3,
        RS_FAULT = 3'd4
    } remote_state_t;
endpackage

// File: rtl/pin_sync_filter.sv
// Two-flop synchronizer followed by a stable-count filter for an inter-board pin.
module pin_sync_filter #(
    parameter int FILTER_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic rx_f
);
    localparam int CW = $clog2(FILTER_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

    logic          s1;
    logic          rx_s;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= 1'b0;
            rx_s <= 1'b0;
            rx_f <= 1'b0;
            cnt  <= '0;
        end else begin
            s1   <= pin;
            rx_s <= s1;
            // a new level must differ from rx_f for FILTER_CYCLES samples in a row
            if (rx_s == rx_f) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                rx_f <= rx_s;
                cnt  <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: rtl/turn_remote_fsm.sv
// Replays the opponent's turn (hold/aim, then a timed throw) from the filtered link pin.
module turn_remote_fsm
    import turn_pkg::*;
#(
    parameter int THROW_CYCLES    = ONE_SECOND,
    parameter int FILTER_CYCLES   = 16,
    parameter int MAX_HOLD_CYCLES = 325000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       space_pin_rx,
    input  logic       local_busy,
    output logic       enable_draw,
    output logic [1:0] index,
    output logic       throw_enable,
    output logic       turn_done,
    output logic       rx_fault
);
    localparam logic [31:0] HOLD_LAST  = 32'(MAX_HOLD_CYCLES - 1);
    localparam logic [31:0] THROW_LAST = 32'(THROW_CYCLES - 1);

    logic          rx_f;
    remote_state_t state, state_d;
    logic          armed, armed_d;
    logic [31:0]   cnt, cnt_d;

    pin_sync_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_rx_filter (
        .clk  (clk),
        .rst  (rst),
        .pin  (space_pin_rx),
        .rx_f (rx_f)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RS_IDLE;
            armed <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_d;
            armed <= armed_d;
            cnt   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state;
        armed_d = armed;
        case (state)
            RS_IDLE: begin
                // armed tracks "pin seen low since entering IDLE", so a level
                // that rose while busy or was already high cannot start a turn
                armed_d = !rx_f;
                if (armed && rx_f && !local_busy) begin
                    state_d = RS_HOLD;
                    armed_d = 1'b0;
                end
            end
            RS_HOLD: begin
                if (!rx_f)                  state_d = RS_THROW;
                else if (cnt == HOLD_LAST)  state_d = RS_FAULT;
            end
            RS_THROW: begin
                if (cnt == THROW_LAST) state_d = RS_DONE;
            end
            RS_DONE: state_d = RS_IDLE;
            RS_FAULT: begin
                if (!rx_f) begin
                    state_d = RS_IDLE;
                    armed_d = 1'b1;
                end
            end
            default: state_d = RS_IDLE;
        endcase

        if (state_d != state || !(state == RS_HOLD || state == RS_THROW))
            cnt_d = '0;
        else
            cnt_d = cnt + 32'd1;
    end

    always_comb begin
        enable_draw  = 1'b0;
        index        = IDX_IDLE;
        throw_enable = 1'b0;
        turn_done    = 1'b0;
        rx_fault     = 1'b0;
        case (state)
            RS_HOLD: begin
                enable_draw = 1'b1;
                index       = IDX_HOLD;
            end
            RS_THROW: begin
                throw_enable = 1'b1;
                index        = IDX_THROW;
            end
            RS_DONE: begin
                turn_done = 1'b1;
                index     = IDX_THROW;
            end
            RS_FAULT: rx_fault = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_turn_remote_fsm.sv
// Scoreboard bench: a cycle-level behavioural model predicts outputs, a monitor compares.
module tb_turn_remote_fsm;
    localparam int F = 4;
    localparam int T = 10;
    localparam int M = 50;

    localparam int P_IDLE  = 0;
    localparam int P_HOLD  = 1;
    localparam int P_THROW = 2;
    localparam int P_DONE  = 3;
    localparam int P_FAULT = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       space_pin_rx = 1'b1;
    logic       local_busy = 1'b0;
    logic       enable_draw;
    logic [1:0] index;
    logic       throw_enable;
    logic       turn_done;
    logic       rx_fault;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc_no   = 0;
    logic [5:0] exp_q[$];

    // model state: pin history, filtered level, phase and time spent in phase
    bit m_s1 = 0, m_s2 = 0, m_rxf = 0, m_armed = 0;
    int m_run = 0, m_phase = P_IDLE, m_age = 0;

    turn_remote_fsm #(
        .THROW_CYCLES   (T),
        .FILTER_CYCLES  (F),
        .MAX_HOLD_CYCLES(M)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .space_pin_rx (space_pin_rx),
        .local_busy   (local_busy),
        .enable_draw  (enable_draw),
        .index        (index),
        .throw_enable (throw_enable),
        .turn_done    (turn_done),
        .rx_fault     (rx_fault)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] phase_outputs(input int ph);
        // {enable_draw, index, throw_enable, turn_done, rx_fault}
        case (ph)
            P_HOLD:  return 6'b1_01_0_0_0;
            P_THROW: return 6'b0_10_1_0_0;
            P_DONE:  return 6'b0_10_0_1_0;
            P_FAULT: return 6'b0_00_0_0_1;
            default: return 6'b0_00_0_0_0;
        endcase
    endfunction

    task automatic model_edge(input bit p, input bit b, input bit r);
        bit rxs, rxf_seen;
        int nxt;
        if (r) begin
            m_s1 = 0; m_s2 = 0; m_rxf = 0; m_armed = 0;
            m_run = 0; m_phase = P_IDLE; m_age = 0;
        end else begin
            rxs      = m_s2;
            rxf_seen = m_rxf;
            if (rxs == m_rxf) m_run = 0;
            else if (m_run == F - 1) begin m_rxf = rxs; m_run = 0; end
            else m_run = m_run + 1;
            m_s2 = m_s1;
            m_s1 = p;

            nxt = m_phase;
            case (m_phase)
                P_IDLE: begin
                    if (m_armed && rxf_seen && !b) begin nxt = P_HOLD; m_armed = 0; end
                    else m_armed = !rxf_seen;
                end
                P_HOLD: begin
                    if (!rxf_seen) nxt = P_THROW;
                    else if (m_age + 1 == M) nxt = P_FAULT;
                end
                P_THROW: if (m_age + 1 == T) nxt = P_DONE;
                P_DONE:  nxt = P_IDLE;
                default: if (!rxf_seen) begin nxt = P_IDLE; m_armed = 1; end
            endcase
            m_age   = (nxt == m_phase) ? m_age + 1 : 0;
            m_phase = nxt;
        end
        exp_q.push_back(phase_outputs(m_phase));
    endtask

    task automatic cyc(input bit p, input bit b, input bit r);
        @(negedge clk);
        space_pin_rx = p;
        local_busy   = b;
        rst          = r;
        model_edge(p, b, r);
    endtask

    task automatic run(input int n, input bit p, input bit b);
        for (int i = 0; i < n; i++) cyc(p, b, 1'b0);
    endtask

    always begin
        logic [5:0] got, e;
        @(posedge clk);
        #1;
        cyc_no++;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {enable_draw, index, throw_enable, turn_done, rx_fault};
            n_checks++;
            if (got !== e) begin
                n_fails++;
                $display("FAIL outputs cycle %0d: got {draw,idx,throw,done,fault}=%b, expected %b",
                         cyc_no, got, e);
            end
        end
    end

    initial begin
        // reset with pin high, then no turn until the pin has been low
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1);
        run(20, 1'b1, 1'b0);
        // normal turn
        run(10, 1'b0, 1'b0);
        run(20, 1'b1, 1'b0);
        run(25, 1'b0, 1'b0);
        // 3-cycle glitch rejected, 4-cycle glitch accepted
        run(3, 1'b1, 1'b0);
        run(15, 1'b0, 1'b0);
        run(4, 1'b1, 1'b0);
        run(30, 1'b0, 1'b0);
        // rise while busy, busy drops with pin high, then a fresh rise starts
        run(15, 1'b1, 1'b1);
        run(10, 1'b1, 1'b0);
        run(10, 1'b0, 1'b0);
        run(20, 1'b1, 1'b1 & 1'b0);
        run(25, 1'b0, 1'b0);
        // stuck-high link: hold timeout then fault, no throw on release
        run(80, 1'b1, 1'b0);
        run(20, 1'b0, 1'b0);
        // reset in the fifth throw cycle
        run(15, 1'b1, 1'b0);
        run(11, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        run(5, 1'b0, 1'b0);
        run(15, 1'b1, 1'b0);
        run(20, 1'b0, 1'b0);
        // busy raised mid-turn is ignored
        run(12, 1'b1, 1'b0);
        run(8, 1'b1, 1'b1);
        run(25, 1'b0, 1'b1);
        run(10, 1'b0, 1'b0);
        // randomized segments
        for (int s = 0; s < 300; s++) begin
            int len;
            bit p, b;
            len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(40, 70))
                                              : int'($urandom_range(1, 12));
            p = 1'($urandom_range(0, 1));
            b = ($urandom_range(0, 3) == 0);
            for (int k = 0; k < len; k++) cyc(p, b, ($urandom_range(0, 199) == 0));
        end
        run(5, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fails++;
            $display("FAIL scoreboard_drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
